// File: rtl/pixel_threshold.sv
// Streaming binarizer: thresholds each grayscale pixel and emits one registered
// binary pixel per clock, with frame position and per-frame foreground count.
module pixel_threshold #(
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 4096,
  parameter int CNT_W        = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic [DATA_W-1:0] threshold,
  input  logic              pixel_valid,
  input  logic              invert,
  output logic              binary_out,
  output logic              binary_valid,
  output logic              frame_done,
  output logic [CNT_W-1:0]  ones_count,
  output logic [CNT_W-1:0]  pixel_index
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_PIXELS - 1);

  logic             w_raw;
  logic             w_result;
  logic             w_last;
  logic [CNT_W-1:0] w_accNext;

  logic             r_binary;
  logic             r_valid;
  logic             r_frameDone;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] r_index;
  logic [CNT_W-1:0] r_pos;
  logic [CNT_W-1:0] r_acc;

  // Equality counts as background; invert flips the foreground polarity.
  assign w_raw     = (pixel_in > threshold);
  assign w_result  = w_raw ^ invert;
  assign w_last    = (r_pos == LAST_POS);
  assign w_accNext = r_acc + CNT_W'(w_result);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_binary    <= 1'b0;
      r_valid     <= 1'b0;
      r_frameDone <= 1'b0;
      r_ones      <= '0;
      r_index     <= '0;
      r_pos       <= '0;
      r_acc       <= '0;
    end else begin
      r_valid     <= pixel_valid;
      r_frameDone <= 1'b0;
      if (pixel_valid) begin
        r_binary <= w_result;
        r_index  <= r_pos;
        // The last pixel of a frame is folded into the published count.
        if (w_last) begin
          r_pos       <= '0;
          r_acc       <= '0;
          r_ones      <= w_accNext;
          r_frameDone <= 1'b1;
        end else begin
          r_pos <= r_pos + CNT_W'(1);
          r_acc <= w_accNext;
        end
      end
    end
  end

  assign binary_out   = r_binary;
  assign binary_valid = r_valid;
  assign frame_done   = r_frameDone;
  assign ones_count   = r_ones;
  assign pixel_index  = r_index;

endmodule

// File: tb/tb_pixel_threshold.sv
// Scoreboard bench for pixel_threshold: a frame-level reference model queues
// expected results, and a monitor compares them whenever binary_valid is high.
module tb_pixel_threshold;

  localparam int DATA_W       = 8;
  localparam int FRAME_PIXELS = 4096;
  localparam int CNT_W        = 13;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] pixel_in;
  logic [DATA_W-1:0] threshold;
  logic              pixel_valid;
  logic              invert;
  logic              binary_out;
  logic              binary_valid;
  logic              frame_done;
  logic [CNT_W-1:0]  ones_count;
  logic [CNT_W-1:0]  pixel_index;

  typedef struct {
    logic bin;
    int   idx;
    logic fd;
    int   ones;
  } exp_t;

  exp_t expQ[$];
  logic frameBits[$];
  int   lastOnes;
  int   checks;
  int   failures;
  logic prevOut;
  int   prevIdx;
  int   fullPix[FRAME_PIXELS];

  pixel_threshold #(
    .DATA_W(DATA_W), .FRAME_PIXELS(FRAME_PIXELS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .threshold(threshold),
    .pixel_valid(pixel_valid), .invert(invert), .binary_out(binary_out),
    .binary_valid(binary_valid), .frame_done(frame_done),
    .ones_count(ones_count), .pixel_index(pixel_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of results accepted so far; its
  // length is the position and its sum is the foreground count.
  task automatic applyStimulus(input int pix, input int thr, input logic inv, input logic vld);
    exp_t e;
    int   sum;
    @(negedge clk);
    pixel_in    = DATA_W'(pix);
    threshold   = DATA_W'(thr);
    invert      = inv;
    pixel_valid = vld;
    if (vld) begin
      e.bin = ((pix > thr) ? 1'b1 : 1'b0) ^ inv;
      e.idx = frameBits.size();
      frameBits.push_back(e.bin);
      if (frameBits.size() == FRAME_PIXELS) begin
        sum = 0;
        foreach (frameBits[k]) sum += int'(frameBits[k]);
        lastOnes = sum;
        frameBits.delete();
        e.fd = 1'b1;
      end else begin
        e.fd = 1'b0;
      end
      e.ones = lastOnes;
      expQ.push_back(e);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic doReset(input string tag);
    @(negedge clk);
    pixel_valid = 1'b0;
    pixel_in    = DATA_W'($urandom);
    threshold   = DATA_W'($urandom);
    invert      = 1'($urandom);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, " binary_out"},   int'(binary_out),   0);
    checkOutput({tag, " binary_valid"}, int'(binary_valid), 0);
    checkOutput({tag, " frame_done"},   int'(frame_done),   0);
    checkOutput({tag, " ones_count"},   int'(ones_count),   0);
    checkOutput({tag, " pixel_index"},  int'(pixel_index),  0);
    checkOutput({tag, " pending queue"}, expQ.size(), 0);
    expQ.delete();
    frameBits.delete();
    lastOnes = 0;
    prevOut  = 1'b0;
    prevIdx  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sample 1 ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (binary_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected binary_valid", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("binary_out",  int'(binary_out),  int'(e.bin));
            checkOutput("pixel_index", int'(pixel_index), e.idx);
            checkOutput("frame_done",  int'(frame_done),  int'(e.fd));
            checkOutput("ones_count",  int'(ones_count),  e.ones);
            prevOut = binary_out;
            prevIdx = int'(pixel_index);
          end
        end else begin
          checkOutput("gap frame_done",  int'(frame_done),  0);
          checkOutput("gap binary_out",  int'(binary_out),  int'(prevOut));
          checkOutput("gap pixel_index", int'(pixel_index), prevIdx);
        end
      end
    end
  end

  initial begin
    #2ms;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int boundary[5];
    int tmp;
    int j;
    checks = 0; failures = 0; lastOnes = 0; prevOut = 1'b0; prevIdx = 0;
    rst_n = 1'b0;
    pixel_in = DATA_W'($urandom); threshold = DATA_W'($urandom);
    invert = 1'($urandom); pixel_valid = 1'($urandom);
    #1;
    checkOutput("power-on binary_out",   int'(binary_out),   0);
    checkOutput("power-on binary_valid", int'(binary_valid), 0);
    checkOutput("power-on pixel_index",  int'(pixel_index),  0);
    checkOutput("power-on ones_count",   int'(ones_count),   0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] boundary compare and invert");
    boundary = '{0, 126, 127, 128, 255};
    foreach (boundary[k]) applyStimulus(boundary[k], 127, 1'b0, 1'b1);
    applyStimulus(127, 127, 1'b1, 1'b1);
    applyStimulus(128, 127, 1'b1, 1'b1);
    applyStimulus(0, 0, 1'b0, 1'b1);
    applyStimulus(1, 0, 1'b1, 1'b1);

    doReset("reset before full frame");
    $display("[TB] full frame with 1000 foreground pixels");
    for (int i = 0; i < FRAME_PIXELS; i++)
      fullPix[i] = (i < 1000) ? int'($urandom_range(128, 255)) : int'($urandom_range(0, 127));
    for (int i = FRAME_PIXELS - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = fullPix[i]; fullPix[i] = fullPix[j]; fullPix[j] = tmp;
    end
    for (int i = 0; i < FRAME_PIXELS; i++) applyStimulus(fullPix[i], 127, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("full frame ones_count", int'(ones_count), 1000);
    checkOutput("full frame frame_done", int'(frame_done), 1);

    $display("[TB] random frame with valid gaps");
    for (int n = 0; n < FRAME_PIXELS + 20; n++) begin
      if (n == 1500) repeat (3) applyStimulus(int'($urandom_range(0, 255)), 100, 1'b0, 1'b0);
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1'($urandom), ($urandom_range(0, 4) != 0));
    end

    $display("[TB] mid-frame reset");
    doReset("reset A");
    for (int n = 0; n < 2000; n++)
      applyStimulus(int'($urandom_range(0, 255)), 90, 1'b0, 1'b1);
    doReset("mid-frame reset");
    for (int n = 0; n < FRAME_PIXELS + 5; n++)
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(60, 200)), 1'($urandom), 1'b1);

    applyStimulus(0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_threshold.md
# pixel_threshold

Streaming binarization stage of the image pipeline. It compares each incoming 8-bit grayscale pixel against a programmable threshold and emits one registered binary pixel per clock. It also tracks frame position and the count of foreground ("1") pixels per frame for downstream feature extraction. It sits between the pixel source (file or sensor buffer, row-major 128x32 frames) and the binary-image consumers.

## Interface
Parameters:
- DATA_W, 8, pixel and threshold width in bits
- FRAME_PIXELS, 4096, pixels per frame (128x32)
- CNT_W, 13, width of pixel/ones counters (must hold FRAME_PIXELS)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pixel_in  input  DATA_W  unsigned grayscale pixel
- threshold  input  DATA_W  unsigned threshold level, sampled every cycle
- pixel_valid  input  1  pixel_in qualifier; the top level ties it high for free-running streams
- invert  input  1  0: foreground = bright, 1: foreground = dark
- binary_out  output  1  registered binarized pixel
- binary_valid  output  1  binary_out qualifier
- frame_done  output  1  one-cycle pulse with the last pixel of a frame
- ones_count  output  CNT_W  number of 1s in the most recently completed frame
- pixel_index  output  CNT_W  index of the pixel currently presented on binary_out

## Operation
- Compare: raw = (pixel_in > threshold), strictly greater, unsigned. raw is 0 when pixel_in equals threshold.
- Result = raw XOR invert.
- On each rising edge with pixel_valid=1:
  - binary_out <= result
  - binary_valid <= 1
  - pixel_index <= internal position counter
  - the position counter increments; it wraps FRAME_PIXELS-1 -> 0
  - the running ones accumulator adds result
- On each rising edge with pixel_valid=0: binary_valid <= 0. binary_out and pixel_index hold their values. Counters do not change.
- Frame end: when the accepted pixel is at position FRAME_PIXELS-1:
  - frame_done <= 1 for one cycle
  - ones_count <= accumulator + result, which includes the last pixel
  - the accumulator clears to 0 for the next frame
- threshold and invert may change on any cycle and take effect on the pixel sampled that same edge. There is no shadowing.
- Reset (rst_n=0, asynchronous, any time, including mid-frame):
  - binary_out=0, binary_valid=0, frame_done=0, ones_count=0, pixel_index=0
  - position counter=0, accumulator=0
  - After release, the first valid pixel is position 0.

## Timing
- Latency: 1 clock from pixel_in/threshold sampling edge to binary_out.
- Throughput: one pixel per clock, no backpressure.
- A pixel applied before edge N appears on binary_out after edge N and is stable until edge N+1. A consumer sampling one clock period after applying the pixel reads that pixel's result.
- frame_done, updated ones_count and binary_out for pixel FRAME_PIXELS-1 all become visible after the same edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 with random inputs, then assert it asynchronously between edges. Required: all outputs 0 immediately. After release, first pixel_index=0.
- Boundary compare: threshold=127, invert=0, pixel_valid=1, pixels 0,126,127,128,255. Required: binary_out 0,0,0,1,1, each one cycle after application.
- Invert and threshold change: threshold=127, invert=1, pixels 127,128 -> 1,0. Then threshold=0 on the same edge as pixel 0 -> 1, and pixel 1 -> 0.
- Full frame: 4096 pixels from a file, threshold=127, with exactly 1000 pixels >127. Required:
  - binary_out matches a per-pixel golden file
  - a single frame_done pulse with the last pixel
  - ones_count=1000
  - pixel_index wraps to 0 on the next frame
- Valid gaps: deassert pixel_valid for 3 cycles mid-frame. Required: binary_valid=0 during the gap, binary_out held, counters frozen, frame_done still on the 4096th accepted pixel.
- Mid-frame reset: reset after 2000 pixels, then stream 4096 pixels. Required: ones_count reflects only the post-reset frame, and frame_done occurs on the 4096th post-reset pixel.
